// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus transmit sequencer feeding a UART transmitter.
// Bytes are popped one at a time and issued over a DV/Active/Done handshake.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  input  logic              i_Wr_En,
  input  logic [7:0]        i_Wr_Data,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow,
  output logic              o_Busy,
  output logic              o_Tx_DV,
  output logic [7:0]        o_Tx_Byte,
  input  logic              i_Tx_Active,
  input  logic              i_Tx_Done
);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ISSUE       = 3'd1,
    ST_WAIT_ACTIVE = 3'd2,
    ST_WAIT_DONE   = 3'd3,
    ST_GUARD       = 3'd4
  } state_e;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;
  logic              tx_dv_q, tx_dv_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  state_e            state_q, state_d;
  logic              push_s, pop_s;

  // Full uses the registered flag, so a same-cycle pop never frees room for this write.
  assign push_s = i_Wr_En && !full_q;
  assign pop_s  = (state_q == ST_ISSUE);

  // Pointer, count, flag and overflow next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (i_Wr_En && full_q) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1'b1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1'b1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == (ADDR_W+1)'(DEPTH));
    empty_d = (count_d == {(ADDR_W+1){1'b0}});
  end

  // Sequencer next-state; DV and the byte are loaded on entry to ISSUE so both are registered.
  always_comb begin
    state_d   = state_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty_q) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE:       state_d = ST_WAIT_ACTIVE;
      ST_WAIT_ACTIVE: begin
        if (i_Tx_Done) begin
          state_d = ST_GUARD;
        end else if (i_Tx_Active) begin
          state_d = ST_WAIT_DONE;
        end else begin
          state_d = ST_WAIT_ACTIVE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_Tx_Done) begin
          state_d = ST_GUARD;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_GUARD:       state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
    if (state_d == ST_ISSUE) begin
      tx_dv_d   = 1'b1;
      tx_byte_d = mem_q[rd_ptr_q];
    end else begin
      tx_dv_d   = 1'b0;
      tx_byte_d = tx_byte_q;
    end
  end

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge i_Clock) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= i_Wr_Data;
    end
  end

  // State and output registers.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wr_ptr_q  <= {ADDR_W{1'b0}};
      rd_ptr_q  <= {ADDR_W{1'b0}};
      count_q   <= {(ADDR_W+1){1'b0}};
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      state_q   <= ST_IDLE;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      state_q   <= state_d;
    end
  end

  assign o_Full     = full_q;
  assign o_Empty    = empty_q;
  assign o_Count    = count_q;
  assign o_Overflow = ovf_q;
  assign o_Tx_DV    = tx_dv_q;
  assign o_Tx_Byte  = tx_byte_q;
  assign o_Busy     = !empty_q || (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a small transmitter stub and an issue/done log.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, ovf, busy, tx_dv;
  logic [4:0] count;
  logic [7:0] tx_byte;
  logic       tx_active, tx_done;

  logic       stub_en, man_active, man_done;
  int         scnt;

  logic [7:0] log_byte [128];
  int         log_cyc [128];
  int         done_edge [128];
  int         n_log = 0, n_done = 0, cyc = 0, dv_b2b = 0;
  logic       prev_dv = 1'b0;

  int n_checks = 0, n_pass = 0;
  int base, dbase;

  uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Wr_En(wr_en), .i_Wr_Data(wr_data),
    .o_Full(full), .o_Empty(empty), .o_Count(count), .o_Overflow(ovf),
    .o_Busy(busy), .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte),
    .i_Tx_Active(tx_active), .i_Tx_Done(tx_done)
  );

  always #5 clk = ~clk;

  // Edge counter and Done log, indexed by the edge that samples Done.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_done) begin
      if (n_done < 128) done_edge[n_done] <= cyc + 1;
      n_done <= n_done + 1;
    end
  end

  // Issue log and back-to-back DV detector.
  always @(negedge clk) begin
    prev_dv <= tx_dv;
    if (tx_dv) begin
      if (prev_dv) dv_b2b <= dv_b2b + 1;
      if (n_log < 128) begin
        log_byte[n_log] <= tx_byte;
        log_cyc[n_log]  <= cyc;
      end
      n_log <= n_log + 1;
    end
  end

  // Transmitter stub: Active shortly after DV, Done pulse about 10 cycles later.
  initial begin
    scnt = 0; tx_active = 1'b0; tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (scnt != 0) scnt = scnt + 1;
      else if (stub_en && tx_dv) scnt = 1;
      tx_done   = man_done || (scnt == 10);
      tx_active = man_active || (scnt >= 2 && scnt <= 9);
      if (scnt == 10) scnt = 0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic pulse_done();
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int nlog_t, input int ndone_t);
    for (int k = 0; k < 800; k++) begin
      if (n_log >= nlog_t && n_done >= ndone_t && empty && !busy) break;
      @(negedge clk);
    end
    check_val(tag, 32'(n_log >= nlog_t && n_done >= ndone_t && !busy), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
    stub_en = 1'b0; man_active = 1'b0; man_done = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_empty", 32'(empty), 32'd1);
    check_val("rst_full", 32'(full), 32'd0);
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_ovf", 32'(ovf), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_dv", 32'(tx_dv), 32'd0);
    check_val("rst_byte", 32'(tx_byte), 32'h00);

    // Single byte latency
    wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    check_val("t1_count_n", 32'(count), 32'd1);
    check_val("t1_dv_n", 32'(tx_dv), 32'd0);
    @(negedge clk);
    check_val("t1_dv_n1", 32'(tx_dv), 32'd1);
    check_val("t1_byte_n1", 32'(tx_byte), 32'hA5);
    check_val("t1_count_n1", 32'(count), 32'd1);
    @(negedge clk);
    check_val("t1_dv_n2", 32'(tx_dv), 32'd0);
    check_val("t1_count_n2", 32'(count), 32'd0);
    check_val("t1_byte_hold", 32'(tx_byte), 32'hA5);
    check_val("t1_busy_wait", 32'(busy), 32'd1);
    pulse_done();
    repeat (3) @(negedge clk);
    check_val("t1_busy_end", 32'(busy), 32'd0);

    // Sixteen bytes through the stub
    stub_en = 1'b1;
    base = n_log; dbase = n_done;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    wait_idle("t2_drain", base + 16, dbase + 16);
    for (int i = 0; i < 16; i++)
      check_val($sformatf("t2_byte%0d", i), 32'(log_byte[base+i]), 32'(i));
    for (int i = 1; i < 16; i++)
      check_val($sformatf("t2_gap%0d", i), 32'(log_cyc[base+i] - done_edge[dbase+i-1]), 32'd2);

    // Stalled transmitter, fill and overflow
    stub_en = 1'b0; man_active = 1'b1;
    base = n_log; dbase = n_done;
    wr_en = 1'b1; wr_data = 8'hEE;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      @(negedge clk);
      if (i == 15) begin
        check_val("t3_full16", 32'(full), 32'd1);
        check_val("t3_count16", 32'(count), 32'd16);
        check_val("t3_ovf_pre", 32'(ovf), 32'd0);
      end
    end
    wr_en = 1'b0;
    check_val("t3_ovf_set", 32'(ovf), 32'd1);
    check_val("t3_count17", 32'(count), 32'd16);
    man_active = 1'b0; stub_en = 1'b1;
    pulse_done();
    wait_idle("t3_drain", base + 17, dbase + 17);
    check_val("t3_first", 32'(log_byte[base]), 32'hEE);
    for (int i = 0; i < 16; i++)
      check_val($sformatf("t3_byte%0d", i), 32'(log_byte[base+1+i]), 32'(i));
    check_val("t3_ovf_sticky", 32'(ovf), 32'd1);

    // Filler so the next burst wraps the pointers
    base = n_log; dbase = n_done;
    for (int i = 0; i < 11; i++) begin
      wr_en = 1'b1; wr_data = 8'h50 + 8'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    wait_idle("t4_fill", base + 11, dbase + 11);

    // Push during ISSUE with count 5 across the wrap
    stub_en = 1'b0; man_active = 1'b1;
    base = n_log; dbase = n_done;
    wr_en = 1'b1; wr_data = 8'hC0;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'hB0 + 8'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    check_val("t4_count5", 32'(count), 32'd5);
    man_active = 1'b0; stub_en = 1'b1;
    pulse_done();
    for (int k = 0; k < 50 && !tx_dv; k++) @(negedge clk);
    check_val("t4_dv_seen", 32'(tx_dv), 32'd1);
    check_val("t4_count_issue", 32'(count), 32'd5);
    wr_en = 1'b1; wr_data = 8'hB5;
    @(negedge clk);
    wr_en = 1'b0;
    check_val("t4_count_same", 32'(count), 32'd5);
    wait_idle("t4_drain", base + 7, dbase + 7);
    check_val("t4_marker", 32'(log_byte[base]), 32'hC0);
    for (int i = 0; i < 6; i++)
      check_val($sformatf("t4_byte%0d", i), 32'(log_byte[base+1+i]), 32'hB0 + 32'(i));

    // Reset while waiting for Done with three bytes queued
    stub_en = 1'b0; man_active = 1'b1;
    wr_en = 1'b1; wr_data = 8'hD0;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 1; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'hD0 + 8'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    check_val("t5_count3", 32'(count), 32'd3);
    check_val("t5_busy", 32'(busy), 32'd1);
    check_val("t5_ovf_still", 32'(ovf), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("t5_rst_count", 32'(count), 32'd0);
    check_val("t5_rst_empty", 32'(empty), 32'd1);
    check_val("t5_rst_full", 32'(full), 32'd0);
    check_val("t5_rst_ovf", 32'(ovf), 32'd0);
    check_val("t5_rst_busy", 32'(busy), 32'd0);
    check_val("t5_rst_dv", 32'(tx_dv), 32'd0);
    check_val("t5_rst_byte", 32'(tx_byte), 32'h00);
    man_active = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = n_log;
    repeat (6) @(negedge clk);
    check_val("t5_no_dv", 32'(n_log - base), 32'd0);
    check_val("t5_idle_busy", 32'(busy), 32'd0);

    // Done pulse while idle and empty
    base = n_log;
    pulse_done();
    repeat (5) @(negedge clk);
    check_val("t6_no_dv", 32'(n_log - base), 32'd0);
    check_val("t6_busy", 32'(busy), 32'd0);
    check_val("t6_empty", 32'(empty), 32'd1);
    check_val("t6_byte", 32'(tx_byte), 32'h00);

    check_val("dv_never_b2b", 32'(dv_b2b), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
